// File: rtl/dram_port_arbiter.sv
// -----------------------------------------------------------------------------
// dram_port_arbiter
//
// Round-robin front end that merges up to NUM_PORTS read/write requesters onto
// the single DRAM user command channel. Reads that are issued are remembered in
// an ID FIFO (port index per outstanding read). Each returning read beat is
// routed back to the port at the FIFO head.
//
// Optional feature macro: DRAM_ARB_ERR_EN
//   When defined, adds the sticky o_err output. It flags two conditions:
//   a read beat that arrives with no read outstanding, and a port that keeps
//   requesting in the cycle after its grant with a different address.
//
// Ports
//   clock, reset           DRAM user clock; asynchronous active-high reset
//   i_ren/i_wen[p]         per-port read/write request, held until granted
//   i_addr/i_wdata/i_wmask packed per-port payload (port p at slice p)
//   o_grant[p]             one-hot pulse: port p's request is taken this cycle
//   o_rdata, o_rvalid[p]   registered read return; o_rvalid selects the owner
//   o_dram_*               registered command register towards the DRAM
//   i_dram_busy            DRAM refuses the command currently presented
//   i_dram_rdata(_valid)   read beats from the DRAM, in issue order
//   o_err                  sticky protocol error (DRAM_ARB_ERR_EN only)
// -----------------------------------------------------------------------------
module dram_port_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 128,
  parameter int MASK_WIDTH = 16,
  parameter int RD_DEPTH   = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             i_ren,
  input  logic [NUM_PORTS-1:0]             i_wen,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  i_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  i_wdata,
  input  logic [NUM_PORTS*MASK_WIDTH-1:0]  i_wmask,
  output logic [NUM_PORTS-1:0]             o_grant,
  output logic [DATA_WIDTH-1:0]            o_rdata,
  output logic [NUM_PORTS-1:0]             o_rvalid,
  output logic                             o_dram_ren,
  output logic                             o_dram_wen,
  output logic [ADDR_WIDTH-1:0]            o_dram_addr,
  output logic [DATA_WIDTH-1:0]            o_dram_wdata,
  output logic [MASK_WIDTH-1:0]            o_dram_wmask,
  input  logic                             i_dram_busy,
  input  logic [DATA_WIDTH-1:0]            i_dram_rdata,
  input  logic                             i_dram_rdata_valid
`ifdef DRAM_ARB_ERR_EN
  ,
  output logic                             o_err
`endif
);

  localparam int PTR_W  = $clog2(RD_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // ---------------------------------------------------------------------------
  // Per-port views of the packed payload buses
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] addr_a  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_PORTS];
  logic [MASK_WIDTH-1:0] wmask_a [NUM_PORTS];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign addr_a[gi]  = i_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[gi] = i_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign wmask_a[gi] = i_wmask[gi*MASK_WIDTH +: MASK_WIDTH];
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                  cr_ren_q,   cr_ren_d;
  logic                  cr_wen_q,   cr_wen_d;
  logic [ADDR_WIDTH-1:0] cr_addr_q,  cr_addr_d;
  logic [DATA_WIDTH-1:0] cr_wdata_q, cr_wdata_d;
  logic [MASK_WIDTH-1:0] cr_wmask_q, cr_wmask_d;
  logic [PORT_W-1:0]     rr_q,       rr_d;
  logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]      count_q,    count_d;
  logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
  logic [NUM_PORTS-1:0]  rvalid_q,   rvalid_d;

  // ID FIFO storage: port index of each outstanding read, oldest at rd_ptr_q
  logic [PORT_W-1:0]     id_mem [RD_DEPTH];
  logic [PORT_W-1:0]     head_id;

  // ---------------------------------------------------------------------------
  // Command register handshake and eligibility
  // ---------------------------------------------------------------------------
  logic                 cr_full;
  logic                 accept;
  logic                 load_en;
  logic                 slot_free;
  logic [NUM_PORTS-1:0] elig;

  assign cr_full   = cr_ren_q | cr_wen_q;
  assign accept    = cr_full & ~i_dram_busy;
  assign load_en   = ~cr_full | accept;
  // count_q already includes a read sitting in the command register
  assign slot_free = (count_q < CNT_W'(RD_DEPTH));
  assign elig      = i_wen | (i_ren & {NUM_PORTS{slot_free}});

  // ---------------------------------------------------------------------------
  // Round-robin pick: first eligible port at or above rr_q, else wrap to the
  // lowest eligible port below rr_q.
  // ---------------------------------------------------------------------------
  logic                 sel_found;
  logic [NUM_PORTS-1:0] sel_onehot;
  logic [PORT_W-1:0]    sel_idx;

  always_comb begin
    sel_found  = 1'b0;
    sel_onehot = '0;
    sel_idx    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!sel_found && elig[p] && (PORT_W'(p) >= rr_q)) begin
        sel_found     = 1'b1;
        sel_onehot[p] = 1'b1;
        sel_idx       = PORT_W'(p);
      end
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!sel_found && elig[p] && (PORT_W'(p) < rr_q)) begin
        sel_found     = 1'b1;
        sel_onehot[p] = 1'b1;
        sel_idx       = PORT_W'(p);
      end
    end
  end

  // Payload of the selected port; a port asking for both gets its write taken
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [MASK_WIDTH-1:0] sel_wmask;

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wmask = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (sel_onehot[p]) begin
        sel_wr    = i_wen[p];
        sel_addr  = addr_a[p];
        sel_wdata = wdata_a[p];
        sel_wmask = wmask_a[p];
      end
    end
  end

  // The reset term keeps the combinational grant quiet while reset is held
  logic do_load;
  logic push;
  logic pop;

  assign do_load = load_en & sel_found & ~reset;
  assign push    = do_load & ~sel_wr;
  // A beat with nothing outstanding is discarded rather than popped
  assign pop     = i_dram_rdata_valid & (count_q != '0);
  assign head_id = id_mem[rd_ptr_q];

  assign o_grant = do_load ? sel_onehot : '0;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    cr_ren_d   = cr_ren_q;
    cr_wen_d   = cr_wen_q;
    cr_addr_d  = cr_addr_q;
    cr_wdata_d = cr_wdata_q;
    cr_wmask_d = cr_wmask_q;
    rr_d       = rr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rdata_d    = rdata_q;
    rvalid_d   = '0;

    if (do_load) begin
      cr_ren_d   = ~sel_wr;
      cr_wen_d   = sel_wr;
      cr_addr_d  = sel_addr;
      cr_wdata_d = sel_wdata;
      cr_wmask_d = sel_wmask;
      rr_d       = (sel_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : sel_idx + PORT_W'(1);
    end else if (accept) begin
      cr_ren_d = 1'b0;
      cr_wen_d = 1'b0;
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (pop) begin
      rdata_d = i_dram_rdata;
      for (int p = 0; p < NUM_PORTS; p++) begin
        rvalid_d[p] = (head_id == PORT_W'(p));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cr_ren_q   <= 1'b0;
      cr_wen_q   <= 1'b0;
      cr_addr_q  <= '0;
      cr_wdata_q <= '0;
      cr_wmask_q <= '0;
      rr_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rdata_q    <= '0;
      rvalid_q   <= '0;
    end else begin
      cr_ren_q   <= cr_ren_d;
      cr_wen_q   <= cr_wen_d;
      cr_addr_q  <= cr_addr_d;
      cr_wdata_q <= cr_wdata_d;
      cr_wmask_q <= cr_wmask_d;
      rr_q       <= rr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // FIFO contents need no reset: validity is tracked by the pointers/count
  always_ff @(posedge clock) begin
    if (push) id_mem[wr_ptr_q] <= sel_idx;
  end

  assign o_dram_ren   = cr_ren_q;
  assign o_dram_wen   = cr_wen_q;
  assign o_dram_addr  = cr_addr_q;
  assign o_dram_wdata = cr_wdata_q;
  assign o_dram_wmask = cr_wmask_q;
  assign o_rdata      = rdata_q;
  assign o_rvalid     = rvalid_q;

`ifdef DRAM_ARB_ERR_EN
  // ---------------------------------------------------------------------------
  // Protocol checking. In the cycle after a grant the command register holds
  // the granted address, so a still-requesting port presenting a different
  // address has failed to drop its request.
  // ---------------------------------------------------------------------------
  logic [NUM_PORTS-1:0] grant_q;
  logic                 err_q, err_d;
  logic                 proto_err;

  always_comb begin
    proto_err = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_q[p] && (i_ren[p] || i_wen[p]) && (addr_a[p] != cr_addr_q)) begin
        proto_err = 1'b1;
      end
    end
    err_d = err_q | proto_err | (i_dram_rdata_valid & (count_q == '0));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_q <= '0;
      err_q   <= 1'b0;
    end else begin
      grant_q <= o_grant;
      err_q   <= err_d;
    end
  end

  assign o_err = err_q;
`endif

endmodule
